amiga_line_scaler: RTL and testbench

AMIGA_LINE_SCALER -- requirements
Module: amiga_line_scaler

---
 rtl/video_pkg.sv | 22 ++
 rtl/line_ram_dp.sv | 27 ++
 rtl/amiga_line_scaler.sv | 153 +++++++++++++++
 tb/tb_amiga_line_scaler.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared types and default geometry for the Amiga-to-HDMI line scaler.
package video_pkg;

    typedef enum logic [1:0] {
        WAIT_VSYNC = 2'd0,
        SKIP       = 2'd1,
        CAPTURE    = 2'd2
    } wr_state_e;

    typedef logic [23:0] rgb24;

    localparam int DEF_SRC_W  = 640;
    localparam int DEF_V_SKIP = 26;
    localparam int DEF_DST_W  = 1280;
    localparam int DEF_DST_H  = 720;
    localparam int PTR_W      = 10;

    function automatic rgb24 pack_rgb(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        return {r, g, b};
    endfunction

endpackage

// File: rtl/line_ram_dp.sv
// Simple dual-port line store: one write port, one registered read port.
module line_ram_dp #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] mem_q [0:(2**ADDR_W)-1];
    logic [DATA_W-1:0] rdata_q;

    // Contents are deliberately left unreset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
        rdata_q <= mem_q[i_raddr];
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/amiga_line_scaler.sv
// Captures Amiga source lines into a ping-pong line store and replays them
// at 2x horizontal repeat into the HDMI timing generator's active area.
module amiga_line_scaler
    import video_pkg::*;
#(
    parameter int SRC_W  = DEF_SRC_W,
    parameter int V_SKIP = DEF_V_SKIP,
    parameter int DST_H  = DEF_DST_H,
    parameter int DST_W  = DEF_DST_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_pix_valid,
    input  logic [7:0]  i_src_r,
    input  logic [7:0]  i_src_g,
    input  logic [7:0]  i_src_b,
    input  logic        i_src_hsync,
    input  logic        i_src_vsync,
    input  logic [11:0] i_x,
    input  logic [11:0] i_y,
    output logic [7:0]  o_r,
    output logic [7:0]  o_g,
    output logic [7:0]  o_b,
    output logic        o_frame_end,
    output logic        o_overflow
);

    localparam int                SKIP_W    = $clog2(V_SKIP + 1);
    localparam logic [PTR_W-1:0]  PTR_MAX   = PTR_W'(SRC_W);
    localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'(V_SKIP - 1);
    localparam logic [11:0]       X_LIMIT   = 12'(DST_W);
    localparam logic [11:0]       Y_LIMIT   = 12'(DST_H);

    wr_state_e         state_q, state_d;
    logic [SKIP_W-1:0] skip_q, skip_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic              wr_bank_q, wr_bank_d;
    logic              hs_prev_q, vs_prev_q;
    logic              hs_edge, vs_edge;
    logic              wr_en;
    logic              overflow_d;
    logic              overflow_q, frame_end_q;
    logic              blank_q, blank_d;
    rgb24              rd_data, pix_out_q, pix_out_d;

    assign hs_edge = i_src_hsync & ~hs_prev_q;
    assign vs_edge = i_src_vsync & ~vs_prev_q;

    // Previous-sync registers come out of reset high so a held sync is not an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            hs_prev_q <= 1'b1;
            vs_prev_q <= 1'b1;
        end else begin
            hs_prev_q <= i_src_hsync;
            vs_prev_q <= i_src_vsync;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= WAIT_VSYNC;
            skip_q      <= '0;
            wr_ptr_q    <= '0;
            wr_bank_q   <= 1'b0;
            frame_end_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            skip_q      <= skip_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_bank_q   <= wr_bank_d;
            frame_end_q <= vs_edge;
            overflow_q  <= overflow_d;
        end
    end

    // A pixel coincident with an hsync edge still lands at the old pointer in
    // the old bank; vsync outranks hsync so a shared edge never swaps banks.
    always_comb begin
        state_d    = state_q;
        skip_d     = skip_q;
        wr_ptr_d   = wr_ptr_q;
        wr_bank_d  = wr_bank_q;
        wr_en      = 1'b0;
        overflow_d = 1'b0;

        if (state_q == CAPTURE && i_pix_valid) begin
            if (wr_ptr_q < PTR_MAX) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                overflow_d = 1'b1;
            end
        end

        if (vs_edge) begin
            state_d  = SKIP;
            skip_d   = '0;
            wr_ptr_d = '0;
        end else if (hs_edge) begin
            case (state_q)
                SKIP: begin
                    if (skip_q == SKIP_LAST) begin
                        state_d = CAPTURE;
                        skip_d  = '0;
                    end else begin
                        skip_d = skip_q + SKIP_W'(1);
                    end
                end
                CAPTURE: begin
                    wr_ptr_d  = '0;
                    wr_bank_d = ~wr_bank_q;
                end
                default: begin
                end
            endcase
        end
    end

    line_ram_dp #(
        .DATA_W(24),
        .ADDR_W(PTR_W + 1)
    ) u_line_ram (
        .clk     (clk),
        .i_we    (wr_en),
        .i_waddr ({wr_bank_q, wr_ptr_q}),
        .i_wdata (pack_rgb(i_src_r, i_src_g, i_src_b)),
        .i_raddr ({~wr_bank_q, i_x[10:1]}),
        .o_rdata (rd_data)
    );

    assign blank_d   = (i_x >= X_LIMIT) || (i_y >= Y_LIMIT) || (state_q != CAPTURE);
    assign pix_out_d = blank_q ? '0 : rd_data;

    // Blank decision rides alongside the RAM read so both reach the output together.
    always_ff @(posedge clk) begin
        if (reset) begin
            blank_q   <= 1'b1;
            pix_out_q <= '0;
        end else begin
            blank_q   <= blank_d;
            pix_out_q <= pix_out_d;
        end
    end

    assign o_r         = pix_out_q[23:16];
    assign o_g         = pix_out_q[15:8];
    assign o_b         = pix_out_q[7:0];
    assign o_frame_end = frame_end_q;
    assign o_overflow  = overflow_q;

endmodule

// File: tb/tb_amiga_line_scaler.sv
// Randomised bench for amiga_line_scaler; a line-buffer model predicts every output.
module tb_amiga_line_scaler;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_pix_valid;
    logic [7:0]  i_src_r, i_src_g, i_src_b;
    logic        i_src_hsync, i_src_vsync;
    logic [11:0] i_x, i_y;
    logic [7:0]  o_r, o_g, o_b;
    logic        o_frame_end, o_overflow;

    always #5 clk = ~clk;

    amiga_line_scaler dut (
        .clk         (clk),
        .reset       (reset),
        .i_pix_valid (i_pix_valid),
        .i_src_r     (i_src_r),
        .i_src_g     (i_src_g),
        .i_src_b     (i_src_b),
        .i_src_hsync (i_src_hsync),
        .i_src_vsync (i_src_vsync),
        .i_x         (i_x),
        .i_y         (i_y),
        .o_r         (o_r),
        .o_g         (o_g),
        .o_b         (o_b),
        .o_frame_end (o_frame_end),
        .o_overflow  (o_overflow)
    );

    int testsRun = 0;
    int testsFailed = 0;
    int frameEndCount = 0;
    int overflowCount = 0;

    // Model: the line being displayed and the line being filled.
    logic [23:0] completedLine [640];
    logic [23:0] currentLine [640];
    int modelPtr = 0;

    always @(negedge clk) begin
        if (o_frame_end) frameEndCount++;
        if (o_overflow) overflowCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [23:0] pix, input logic hs, input logic vs);
        i_pix_valid = v;
        {i_src_r, i_src_g, i_src_b} = pix;
        i_src_hsync = hs;
        i_src_vsync = vs;
        tick();
    endtask

    task automatic modelPixel(input logic [23:0] pix);
        if (modelPtr < 640) begin
            currentLine[modelPtr] = pix;
            modelPtr++;
        end
    endtask

    task automatic modelSwap();
        logic [23:0] tmp;
        for (int i = 0; i < 640; i++) begin
            tmp = completedLine[i];
            completedLine[i] = currentLine[i];
            currentLine[i] = tmp;
        end
        modelPtr = 0;
    endtask

    task automatic sendPixels(input int n);
        logic [23:0] pix;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) applyStimulus(1'b0, 24'h0, 1'b0, 1'b0);
            pix = 24'($urandom);
            applyStimulus(1'b1, pix, 1'b0, 1'b0);
            modelPixel(pix);
        end
    endtask

    // patterned: pixel k = {k,k,k}; coincident: last pixel shares the hsync edge.
    task automatic sendLine(input int n, input bit patterned, input bit coincident);
        logic [23:0] pix;
        logic [7:0]  k8;
        bit          last;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) applyStimulus(1'b0, 24'h0, 1'b0, 1'b0);
            k8 = k[7:0];
            pix = patterned ? {k8, k8, k8} : 24'($urandom);
            last = coincident && (k == n - 1);
            applyStimulus(1'b1, pix, last, 1'b0);
            modelPixel(pix);
            if (last) modelSwap();
        end
        if (!coincident) begin
            applyStimulus(1'b0, 24'h0, 1'b1, 1'b0);
            modelSwap();
        end
        applyStimulus(1'b0, 24'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 24'h0, 1'b0, 1'b0);
    endtask

    task automatic hsyncPulses(input int n);
        repeat (n) begin
            applyStimulus(1'b0, 24'h0, 1'b1, 1'b0);
            repeat ($urandom_range(1, 3)) applyStimulus(1'b0, 24'h0, 1'b0, 1'b0);
        end
    endtask

    // Back-to-back beam positions; each result is checked exactly two clocks later.
    task automatic readCheck(input string tag, input bit blank, input int n);
        int xs[$];
        int ys[$];
        int fx[11] = '{0, 1, 8, 598, 599, 600, 1278, 1279, 1280, 600, 4095};
        int fy[11] = '{0, 100, 719, 5, 50, 300, 700, 10, 10, 720, 4095};
        logic [23:0] exp;
        for (int i = 0; i < 11; i++) begin
            xs.push_back(fx[i]);
            ys.push_back(fy[i]);
        end
        for (int i = 0; i < n; i++) begin
            xs.push_back(int'($urandom_range(0, 1279)));
            ys.push_back(int'($urandom_range(0, 719)));
        end
        for (int i = 0; i <= xs.size(); i++) begin
            if (i < xs.size()) begin
                i_x = 12'(xs[i]);
                i_y = 12'(ys[i]);
            end else begin
                i_x = '0;
                i_y = '0;
            end
            tick();
            if (i >= 1) begin
                if (blank || xs[i-1] >= 1280 || ys[i-1] >= 720) exp = '0;
                else exp = completedLine[xs[i-1] / 2];
                checkOutput($sformatf("%s x=%0d y=%0d", tag, xs[i-1], ys[i-1]), {8'h0, o_r, o_g, o_b}, {8'h0, exp});
            end
        end
    endtask

    initial begin
        int ovBefore;
        int feBefore;
        for (int i = 0; i < 640; i++) begin
            completedLine[i] = '0;
            currentLine[i] = '0;
        end
        reset = 1'b1;
        i_pix_valid = 1'b0;
        {i_src_r, i_src_g, i_src_b} = '0;
        i_src_hsync = 1'b1;
        i_src_vsync = 1'b1;
        i_x = '0;
        i_y = '0;
        repeat (3) tick();
        reset = 1'b0;
        repeat (2) tick();
        checkOutput("reset rgb", {8'h0, o_r, o_g, o_b}, 32'h0);
        checkOutput("reset frame_end", {31'h0, o_frame_end}, 32'h0);
        checkOutput("reset overflow", {31'h0, o_overflow}, 32'h0);
        checkOutput("held syncs no frame_end", frameEndCount, 0);
        applyStimulus(1'b0, 24'h0, 1'b0, 1'b0);

        applyStimulus(1'b0, 24'h0, 1'b0, 1'b1);
        checkOutput("frame_end after vsync", {31'h0, o_frame_end}, 32'h1);
        applyStimulus(1'b0, 24'h0, 1'b0, 1'b0);
        checkOutput("frame_end one cycle", {31'h0, o_frame_end}, 32'h0);

        hsyncPulses(25);
        readCheck("skip blank", 1'b1, 6);
        hsyncPulses(1);

        sendLine(640, 1'b1, 1'b0);
        readCheck("pattern line", 1'b0, 24);

        ovBefore = overflowCount;
        sendLine(650, 1'b0, 1'b0);
        checkOutput("overflow pulses", overflowCount - ovBefore, 10);
        readCheck("after overflow", 1'b0, 24);

        sendLine(300, 1'b0, 1'b1);
        readCheck("coincident pixel", 1'b0, 24);
        sendLine(5, 1'b0, 1'b0);
        readCheck("restart at 0", 1'b0, 16);

        sendPixels(100);
        feBefore = frameEndCount;
        applyStimulus(1'b0, 24'h0, 1'b1, 1'b1);
        modelPtr = 0;
        checkOutput("frame_end vs+hs", {31'h0, o_frame_end}, 32'h1);
        applyStimulus(1'b0, 24'h0, 1'b0, 1'b0);
        checkOutput("frame_end vs+hs one cycle", {31'h0, o_frame_end}, 32'h0);
        hsyncPulses(10);
        applyStimulus(1'b0, 24'h0, 1'b1, 1'b1);
        applyStimulus(1'b0, 24'h0, 1'b0, 1'b0);
        hsyncPulses(25);
        readCheck("skip restarted", 1'b1, 6);
        hsyncPulses(1);
        readCheck("no swap on vsync", 1'b0, 24);
        checkOutput("frame_end count", frameEndCount - feBefore, 2);

        sendLine(20, 1'b0, 1'b0);
        readCheck("ptr cleared by vsync", 1'b0, 16);

        sendPixels(50);
        reset = 1'b1;
        repeat (3) applyStimulus(1'b0, 24'h0, 1'b0, 1'b1);
        feBefore = frameEndCount;
        reset = 1'b0;
        repeat (5) applyStimulus(1'b0, 24'h0, 1'b0, 1'b1);
        readCheck("after mid-line reset", 1'b1, 6);
        checkOutput("no frame_end after reset", frameEndCount - feBefore, 0);
        hsyncPulses(30);
        readCheck("still waiting vsync", 1'b1, 6);
        checkOutput("overflow total", overflowCount, 10);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
